// File: rtl/mcif_rd_req_gen_pkg.sv
// Shared definitions for the MCIF read-request sequencer: payload field
// positions, the 4 KB page constants and the sequencer state encoding.
package mcif_rd_req_gen_pkg;

  // rd_req_pd = {len-1, base, offset}; LEN occupies [BURST_LEN_W+63:PD_LEN_LSB]
  localparam int unsigned PD_OFF_LSB  = 0;
  localparam int unsigned PD_BASE_LSB = 32;
  localparam int unsigned PD_LEN_LSB  = 64;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_OFF_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Bytes left before the next 4 KB boundary (1..4096).
  function automatic logic [PAGE_OFF_W:0] bytes_to_page(input logic [PAGE_OFF_W-1:0] page_addr);
    return {1'b1, {PAGE_OFF_W{1'b0}}} - {1'b0, page_addr};
  endfunction

endpackage

// File: rtl/mcif_burst_split.sv
// Combinational burst sizer: largest burst that fits the line remainder,
// the AXI burst limit and the distance to the next 4 KB boundary.
module mcif_burst_split
  import mcif_rd_req_gen_pkg::*;
#(
  parameter int MAX_BURST       = 16,
  parameter int LOG2_BEAT_BYTES = 6,
  parameter int CNT_W           = 16,
  parameter int BURST_W         = $clog2(MAX_BURST + 1)
) (
  input  logic [PAGE_OFF_W-1:0] page_addr,
  input  logic [CNT_W-1:0]      remaining,
  output logic [BURST_W-1:0]    burst
);

  logic [PAGE_OFF_W:0] page_beats;
  logic [31:0]         limit;

  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    page_beats = bytes_to_page(page_addr) >> LOG2_BEAT_BYTES;
    limit      = 32'(MAX_BURST);
    if (32'(page_beats) < limit) limit = 32'(page_beats);
    if (32'(remaining) < limit)  limit = 32'(remaining);
    burst = BURST_W'(limit);
  end

endmodule

// File: rtl/mcif_rd_req_gen.sv
// Read-request sequencer for one MCIF client port: splits a 2D fetch command
// into 4 KB-safe bursts, issues them and tracks returned beats until done.
module mcif_rd_req_gen
  import mcif_rd_req_gen_pkg::*;
#(
  parameter int BURST_LEN_W     = 8,
  parameter int MAX_BURST       = 16,
  parameter int LOG2_BEAT_BYTES = 6,
  parameter int CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_vld,
  output logic                    cmd_rdy,
  input  logic [31:0]             cmd_base,
  input  logic [31:0]             cmd_offset,
  input  logic [CNT_W-1:0]        cmd_line_beats,
  input  logic [CNT_W-1:0]        cmd_line_num,
  input  logic [31:0]             cmd_line_stride,
  output logic                    rd_req_vld,
  input  logic                    rd_req_rdy,
  output logic [BURST_LEN_W+63:0] rd_req_pd,
  input  logic                    rd_resp_vld,
  input  logic                    rd_resp_rdy,
  output logic                    busy,
  output logic                    done
);

  localparam int          BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [31:0] BEAT_MASK = ~((32'd1 << LOG2_BEAT_BYTES) - 32'd1);

  state_e                  state_q, state_d;
  logic [31:0]             base_q, stride_q, line_start_q, cur_off_q;
  logic [CNT_W-1:0]        line_beats_q, line_rem_q, lines_left_q;
  logic [BURST_W-1:0]      burst_q;
  logic [31:0]             issued_q, recv_q;
  logic                    req_vld_q;
  logic [BURST_LEN_W+63:0] req_pd_q;

  logic                    cmd_fire, req_fire, resp_fire;
  logic                    line_last, cmd_last, drain_done;
  logic [31:0]             recv_nxt;
  logic [31:0]             nxt_base, nxt_line_start, nxt_off, nxt_off_al;
  logic [CNT_W-1:0]        nxt_rem, nxt_lines;
  logic                    nxt_vld, load_req;
  logic [31:0]             nxt_addr;
  logic [BURST_W-1:0]      nxt_burst, nxt_len_m1;

  assign cmd_fire  = cmd_vld & cmd_rdy;
  assign req_fire  = req_vld_q & rd_req_rdy;
  assign resp_fire = rd_resp_vld & rd_resp_rdy;

  assign line_last  = (line_rem_q == CNT_W'(burst_q));
  assign cmd_last   = line_last && (lines_left_q == CNT_W'(1));
  assign recv_nxt   = recv_q + 32'(resp_fire);
  // A beat landing in the final cycle completes the command in that same cycle.
  assign drain_done = (state_q == ST_DRAIN) && (recv_nxt == issued_q);

  assign done       = drain_done;
  assign busy       = (state_q != ST_IDLE) && !drain_done;
  assign cmd_rdy    = (state_q == ST_IDLE) || drain_done;
  assign rd_req_vld = req_vld_q;
  assign rd_req_pd  = req_pd_q;

  // Next walk position; the burst for the next request is sized from it so
  // request payloads can be registered one cycle ahead.
  always_comb begin
    state_d        = state_q;
    nxt_base       = base_q;
    nxt_line_start = line_start_q;
    nxt_off        = cur_off_q;
    nxt_rem        = line_rem_q;
    nxt_lines      = lines_left_q;
    nxt_vld        = req_vld_q;
    load_req       = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_ISSUE: begin
        if (req_fire) begin
          if (cmd_last) begin
            state_d = ST_DRAIN;
            nxt_vld = 1'b0;
          end else begin
            if (line_last) begin
              nxt_line_start = line_start_q + stride_q;
              nxt_off        = line_start_q + stride_q;
              nxt_rem        = line_beats_q;
              nxt_lines      = lines_left_q - CNT_W'(1);
            end else begin
              nxt_off = cur_off_q + (32'(burst_q) << LOG2_BEAT_BYTES);
              nxt_rem = line_rem_q - CNT_W'(burst_q);
            end
            load_req = 1'b1;
          end
        end
      end
      ST_DRAIN: if (drain_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (cmd_fire) begin
      nxt_base       = cmd_base;
      nxt_line_start = cmd_offset;
      nxt_off        = cmd_offset;
      nxt_rem        = cmd_line_beats;
      nxt_lines      = cmd_line_num;
      if (cmd_line_beats == '0 || cmd_line_num == '0) begin
        state_d = ST_DRAIN;
        nxt_vld = 1'b0;
      end else begin
        state_d  = ST_ISSUE;
        nxt_vld  = 1'b1;
        load_req = 1'b1;
      end
    end
  end

  assign nxt_off_al = nxt_off & BEAT_MASK;
  assign nxt_addr   = nxt_base + nxt_off_al;
  assign nxt_len_m1 = nxt_burst - BURST_W'(1);

  mcif_burst_split #(
    .MAX_BURST       (MAX_BURST),
    .LOG2_BEAT_BYTES (LOG2_BEAT_BYTES),
    .CNT_W           (CNT_W),
    .BURST_W         (BURST_W)
  ) u_burst_split (
    .page_addr (nxt_addr[PAGE_OFF_W-1:0]),
    .remaining (nxt_rem),
    .burst     (nxt_burst)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      stride_q     <= '0;
      line_start_q <= '0;
      cur_off_q    <= '0;
      line_beats_q <= '0;
      line_rem_q   <= '0;
      lines_left_q <= '0;
      burst_q      <= '0;
      issued_q     <= '0;
      recv_q       <= '0;
      req_vld_q    <= 1'b0;
      req_pd_q     <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= nxt_base;
      line_start_q <= nxt_line_start;
      cur_off_q    <= nxt_off;
      line_rem_q   <= nxt_rem;
      lines_left_q <= nxt_lines;
      req_vld_q    <= nxt_vld;
      if (load_req) begin
        burst_q  <= nxt_burst;
        req_pd_q <= {BURST_LEN_W'(nxt_len_m1), nxt_base, nxt_off_al};
      end
      if (cmd_fire) begin
        stride_q     <= cmd_line_stride;
        line_beats_q <= cmd_line_beats;
        issued_q     <= '0;
        recv_q       <= '0;
      end else begin
        if (req_fire) issued_q <= issued_q + 32'(burst_q);
        // Beats arriving with no command in flight are stray and dropped.
        if (resp_fire && state_q != ST_IDLE) recv_q <= recv_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mcif_rd_req_gen.sv
// Self-checking bench for mcif_rd_req_gen: directed plan cases plus random
// commands, checked against a burst-list model built from plain arithmetic.
module tb_mcif_rd_req_gen;

  localparam int CNT_W  = 16;
  localparam int PD_W   = 72;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_vld;
  logic             cmd_rdy;
  logic [31:0]      cmd_base, cmd_offset, cmd_line_stride;
  logic [CNT_W-1:0] cmd_line_beats, cmd_line_num;
  logic             rd_req_vld, rd_req_rdy;
  logic [PD_W-1:0]  rd_req_pd;
  logic             rd_resp_vld, rd_resp_rdy;
  logic             busy, done;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [PD_W-1:0]  exp_q[$];
  int               total;

  always #5 clk = ~clk;

  mcif_rd_req_gen #(
    .BURST_LEN_W     (8),
    .MAX_BURST       (16),
    .LOG2_BEAT_BYTES (6),
    .CNT_W           (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_base        (cmd_base),
    .cmd_offset      (cmd_offset),
    .cmd_line_beats  (cmd_line_beats),
    .cmd_line_num    (cmd_line_num),
    .cmd_line_stride (cmd_line_stride),
    .rd_req_vld      (rd_req_vld),
    .rd_req_rdy      (rd_req_rdy),
    .rd_req_pd       (rd_req_pd),
    .rd_resp_vld     (rd_resp_vld),
    .rd_resp_rdy     (rd_resp_rdy),
    .busy            (busy),
    .done            (done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected burst list: walk each line in 64 B beats, cutting at 16 beats
  // and at every 4 KB page edge.
  task automatic plan_cmd(input logic [31:0] base, input logic [31:0] off, input int lb,
                          input int ln, input logic [31:0] stride);
    exp_q.delete();
    total = lb * ln;
    for (int i = 0; i < ln; i++) begin
      logic [31:0] cur;
      logic [31:0] a;
      int          rem, room, b;
      cur = off + stride * 32'(i);
      rem = lb;
      while (rem > 0) begin
        a    = base + (cur & 32'hFFFF_FFC0);
        room = (4096 - int'(a[11:0])) / 64;
        b    = (rem > 16) ? 16 : rem;
        if (room < b) b = room;
        exp_q.push_back({8'(b - 1), base, cur & 32'hFFFF_FFC0});
        cur = cur + 32'(b * 64);
        rem = rem - b;
      end
    end
  endtask

  task automatic run_cmd(input logic [31:0] base, input logic [31:0] off, input int lb, input int ln,
                         input logic [31:0] stride, input bit rand_hs, input int stall_idx,
                         input int stall_len, input int abort_cyc);
    int   owed, recv, hs, stall_cnt, qn;
    bit   finished, fire, exp_done;
    plan_cmd(base, off, lb, ln, stride);
    owed = 0; recv = 0; hs = 0; stall_cnt = 0; finished = 0;

    @(posedge clk); #1;
    cmd_base = base; cmd_offset = off; cmd_line_beats = CNT_W'(lb);
    cmd_line_num = CNT_W'(ln); cmd_line_stride = stride; cmd_vld = 1'b1;
    @(negedge clk);
    check("cmd_rdy_idle", cmd_rdy, 1);
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    cmd_base = $urandom; cmd_offset = $urandom; cmd_line_stride = $urandom;
    cmd_line_beats = CNT_W'($urandom); cmd_line_num = CNT_W'($urandom);

    for (int c = 1; c <= BUDGET && !finished; c++) begin
      if (abort_cyc != 0 && c == abort_cyc) begin
        rst_n = 1'b0; rd_req_rdy = 1'b0; rd_resp_vld = 1'b0;
        @(negedge clk);
        check("abort_req_vld", rd_req_vld, 0);
        check("abort_busy", busy, 0);
        check("abort_cmd_rdy", cmd_rdy, 1);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (hs == stall_idx && stall_cnt < stall_len) begin
        rd_req_rdy = 1'b0;
        stall_cnt++;
      end else begin
        rd_req_rdy = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      rd_resp_vld = (owed > 0) && (rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1);
      rd_resp_rdy = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;

      @(negedge clk);
      qn   = exp_q.size();
      fire = rd_resp_vld && rd_resp_rdy;
      if (c == 1 && qn > 0) check("first_req_latency", rd_req_vld, 1);
      check("req_vld", rd_req_vld, qn > 0);
      if (rd_req_vld && qn > 0) begin
        check("req_pd", rd_req_pd, exp_q[0]);
        if (rd_req_rdy) begin
          owed += int'(exp_q[0][71:64]) + 1;
          void'(exp_q.pop_front());
          hs++;
        end
      end
      exp_done = (qn == 0) && (recv + int'(fire) == total);
      check("done", done, exp_done);
      check("busy", busy, !exp_done);
      if (fire) begin
        recv++;
        owed--;
      end
      if (exp_done) begin
        check("cmd_rdy_at_done", cmd_rdy, 1);
        finished = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!finished) check("timeout", 0, 1);
    rd_req_rdy = 1'b0; rd_resp_vld = 1'b0; rd_resp_rdy = 1'b0;
    @(negedge clk);
    check("done_single_pulse", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  // Response beats while idle must not count toward the next command.
  task automatic idle_noise(input int n);
    @(posedge clk); #1;
    rd_resp_vld = 1'b1; rd_resp_rdy = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rd_resp_vld = 1'b0; rd_resp_rdy = 1'b0;
  endtask

  initial begin
    logic [31:0] rb, ro, rs;
    int          rlb, rln;
    rst_n = 1'b0; cmd_vld = 1'b0; rd_req_rdy = 1'b0; rd_resp_vld = 1'b0; rd_resp_rdy = 1'b0;
    cmd_base = '0; cmd_offset = '0; cmd_line_stride = '0; cmd_line_beats = '0; cmd_line_num = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_req_vld", rd_req_vld, 0);
    check("rst_req_pd", rd_req_pd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_cmd(32'h1000_0000, 32'h0,   40, 1, 32'h0,    0, -1, 0, 0);
    run_cmd(32'h1000_0000, 32'hF80, 16, 1, 32'h0,    0, -1, 0, 0);
    run_cmd(32'h1000_0000, 32'h0,    4, 3, 32'h1000, 0, -1, 0, 0);
    run_cmd(32'h1000_0000, 32'h0,   40, 1, 32'h0,    0,  1, 5, 0);
    run_cmd(32'h1000_0000, 32'h0,    8, 0, 32'h0,    0, -1, 0, 0);
    run_cmd(32'h1000_0000, 32'h40,   0, 2, 32'h100,  0, -1, 0, 0);
    idle_noise(5);
    run_cmd(32'h1000_0000, 32'h7C0, 20, 2, 32'hFC0,  1, -1, 0, 0);
    run_cmd(32'h1000_0000, 32'h0,  200, 4, 32'h2000, 0, -1, 0, 3);
    run_cmd(32'h1000_0000, 32'h0,   40, 1, 32'h0,    0, -1, 0, 0);

    for (int k = 0; k < 25; k++) begin
      rb  = $urandom & 32'hFFFF_FFC0;
      ro  = $urandom;
      rs  = $urandom & 32'h0000_3FFF;
      rln = $urandom_range(0, 3);
      rlb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      if (k % 5 == 0) idle_noise(2);
      run_cmd(rb, ro, rlb, rln, rs, 1, -1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
